// File: rtl/ppu_timing_monitor_if.sv
// Host/PPU-side signal bundle for the PPU timing monitor.
interface ppu_timing_monitor_if #(
  parameter int unsigned CNT_W = 16
);
  logic             xin_tick_i;
  logic             clear_i;
  logic             snap_ack_i;
  logic             hblank;
  logic             vblank;
  logic             csync_n;
  logic             burst_n;
  logic             snap_valid_o;
  logic [CNT_W-1:0] snap_line_len_o;
  logic [CNT_W-1:0] snap_lines_o;
  logic [CNT_W-1:0] snap_csync_o;
  logic [CNT_W-1:0] snap_frame_o;
  logic             snap_partial_o;
  logic             snap_noburst_o;
  logic             overrun_o;

  // Stimulus/host side.
  modport master (
    output xin_tick_i, clear_i, snap_ack_i, hblank, vblank, csync_n, burst_n,
    input  snap_valid_o, snap_line_len_o, snap_lines_o, snap_csync_o,
           snap_frame_o, snap_partial_o, snap_noburst_o, overrun_o
  );

  // Monitor side.
  modport slave (
    input  xin_tick_i, clear_i, snap_ack_i, hblank, vblank, csync_n, burst_n,
    output snap_valid_o, snap_line_len_o, snap_lines_o, snap_csync_o,
           snap_frame_o, snap_partial_o, snap_noburst_o, overrun_o
  );
endinterface

// File: rtl/ppu_timing_monitor.sv
// Measures PPU line length, lines/frame, csync pulses/frame and frame count;
// publishes one snapshot per frame through a valid/ack handshake.
module ppu_timing_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input logic                 clock,
  input logic                 reset,
  ppu_timing_monitor_if.slave mon
);

  typedef logic [CNT_W-1:0] cnt_t;

  logic [SYNC_STAGES-1:0] hb_sync, vb_sync, cs_sync, bn_sync;
  logic hb_dly, vb_dly, cs_dly;
  logic hb_rise, vb_rise, cs_fall, burst_low;

  cnt_t dot_cnt, line_len, line_cnt, csync_cnt, frame_cnt;
  cnt_t snap_len, snap_lines, snap_csync, snap_frame;
  logic burst_seen, snap_valid, snap_partial, snap_noburst, overrun, partial_pending;

  cnt_t dot_cnt_nxt, line_len_nxt, line_cnt_nxt, csync_cnt_nxt, frame_cnt_nxt;
  cnt_t snap_len_nxt, snap_lines_nxt, snap_csync_nxt, snap_frame_nxt;
  logic burst_seen_nxt, snap_valid_nxt, snap_partial_nxt, snap_noburst_nxt;
  logic overrun_nxt, partial_pending_nxt;

  cnt_t len_close, lines_close, csync_close;
  logic burst_close, load;

  function automatic cnt_t sat_add(input cnt_t a, input logic b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{CNT_W{1'b0}}, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Synchronisers plus edge-detect delay flops; not affected by clear_i.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hb_sync <= '0;
      vb_sync <= '0;
      cs_sync <= '1;
      bn_sync <= '1;
      hb_dly  <= 1'b0;
      vb_dly  <= 1'b0;
      cs_dly  <= 1'b1;
    end else begin
      hb_sync <= {hb_sync[SYNC_STAGES-2:0], mon.hblank};
      vb_sync <= {vb_sync[SYNC_STAGES-2:0], mon.vblank};
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], mon.csync_n};
      bn_sync <= {bn_sync[SYNC_STAGES-2:0], mon.burst_n};
      hb_dly  <= hb_sync[SYNC_STAGES-1];
      vb_dly  <= vb_sync[SYNC_STAGES-1];
      cs_dly  <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign hb_rise   = hb_sync[SYNC_STAGES-1] & ~hb_dly;
  assign vb_rise   = vb_sync[SYNC_STAGES-1] & ~vb_dly;
  assign cs_fall   = ~cs_sync[SYNC_STAGES-1] & cs_dly;
  assign burst_low = ~bn_sync[SYNC_STAGES-1];

  // Frame-closing values include events landing in the vb_rise cycle.
  assign len_close   = hb_rise ? sat_add(dot_cnt, mon.xin_tick_i) : line_len;
  assign lines_close = sat_add(line_cnt, hb_rise);
  assign csync_close = sat_add(csync_cnt, cs_fall);
  assign burst_close = burst_seen | burst_low;
  assign load        = vb_rise & (~snap_valid | mon.snap_ack_i);

  // Next-state for counters, snapshot and flags; clear_i overrides all.
  always_comb begin
    dot_cnt_nxt         = hb_rise ? '0 : sat_add(dot_cnt, mon.xin_tick_i);
    line_len_nxt        = len_close;
    line_cnt_nxt        = lines_close;
    csync_cnt_nxt       = csync_close;
    burst_seen_nxt      = burst_close;
    frame_cnt_nxt       = frame_cnt;
    snap_len_nxt        = snap_len;
    snap_lines_nxt      = snap_lines;
    snap_csync_nxt      = snap_csync;
    snap_frame_nxt      = snap_frame;
    snap_valid_nxt      = snap_valid;
    snap_partial_nxt    = snap_partial;
    snap_noburst_nxt    = snap_noburst;
    overrun_nxt         = overrun;
    partial_pending_nxt = partial_pending;

    if (vb_rise) begin
      line_cnt_nxt   = '0;
      csync_cnt_nxt  = '0;
      burst_seen_nxt = 1'b0;
      frame_cnt_nxt  = frame_cnt + CNT_W'(1);
      if (load) begin
        snap_len_nxt        = len_close;
        snap_lines_nxt      = lines_close;
        snap_csync_nxt      = csync_close;
        snap_frame_nxt      = frame_cnt + CNT_W'(1);
        snap_valid_nxt      = 1'b1;
        snap_partial_nxt    = partial_pending;
        snap_noburst_nxt    = ~burst_close;
        partial_pending_nxt = 1'b0;
      end else begin
        overrun_nxt = 1'b1;
      end
    end else if (mon.snap_ack_i) begin
      snap_valid_nxt = 1'b0;
    end

    if (mon.clear_i) begin
      dot_cnt_nxt         = '0;
      line_len_nxt        = '0;
      line_cnt_nxt        = '0;
      csync_cnt_nxt       = '0;
      burst_seen_nxt      = 1'b0;
      frame_cnt_nxt       = '0;
      snap_len_nxt        = '0;
      snap_lines_nxt      = '0;
      snap_csync_nxt      = '0;
      snap_frame_nxt      = '0;
      snap_valid_nxt      = 1'b0;
      snap_partial_nxt    = 1'b0;
      snap_noburst_nxt    = 1'b0;
      overrun_nxt         = 1'b0;
      partial_pending_nxt = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dot_cnt         <= '0;
      line_len        <= '0;
      line_cnt        <= '0;
      csync_cnt       <= '0;
      burst_seen      <= 1'b0;
      frame_cnt       <= '0;
      snap_len        <= '0;
      snap_lines      <= '0;
      snap_csync      <= '0;
      snap_frame      <= '0;
      snap_valid      <= 1'b0;
      snap_partial    <= 1'b0;
      snap_noburst    <= 1'b0;
      overrun         <= 1'b0;
      partial_pending <= 1'b1;
    end else begin
      dot_cnt         <= dot_cnt_nxt;
      line_len        <= line_len_nxt;
      line_cnt        <= line_cnt_nxt;
      csync_cnt       <= csync_cnt_nxt;
      burst_seen      <= burst_seen_nxt;
      frame_cnt       <= frame_cnt_nxt;
      snap_len        <= snap_len_nxt;
      snap_lines      <= snap_lines_nxt;
      snap_csync      <= snap_csync_nxt;
      snap_frame      <= snap_frame_nxt;
      snap_valid      <= snap_valid_nxt;
      snap_partial    <= snap_partial_nxt;
      snap_noburst    <= snap_noburst_nxt;
      overrun         <= overrun_nxt;
      partial_pending <= partial_pending_nxt;
    end
  end

  assign mon.snap_valid_o    = snap_valid;
  assign mon.snap_line_len_o = snap_len;
  assign mon.snap_lines_o    = snap_lines;
  assign mon.snap_csync_o    = snap_csync;
  assign mon.snap_frame_o    = snap_frame;
  assign mon.snap_partial_o  = snap_partial;
  assign mon.snap_noburst_o  = snap_noburst;
  assign mon.overrun_o       = overrun;

endmodule

// File: tb/tb_ppu_timing_monitor.sv
// Bench for ppu_timing_monitor: directed PPU timing frames, a per-frame
// behavioural model compared every cycle, and literal spot checks.
module tb_ppu_timing_monitor;

  localparam int S    = 2;
  localparam int MAXV = 65535;

  logic clock;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  ppu_timing_monitor_if #(.CNT_W(16)) bus ();

  ppu_timing_monitor #(.SYNC_STAGES(S), .CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .mon   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  bit h_hb[0:S], h_vb[0:S], h_cs[0:S], h_bn[0:S];
  int m_dot, m_len, m_lines, m_cs, m_frame;
  int s_len, s_lines, s_cs, s_frame;
  bit m_burst, m_valid, m_part, m_nob, m_ovr, m_pend;

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic m_clear_state();
    m_dot = 0; m_len = 0; m_lines = 0; m_cs = 0; m_frame = 0; m_burst = 0;
    s_len = 0; s_lines = 0; s_cs = 0; s_frame = 0;
    m_valid = 0; m_part = 0; m_nob = 0; m_ovr = 0; m_pend = 1;
  endtask

  task automatic m_reset();
    m_clear_state();
    for (int k = 0; k <= S; k++) begin
      h_hb[k] = 0; h_vb[k] = 0; h_cs[k] = 1; h_bn[k] = 1;
    end
  endtask

  // Pin history: h_x[k] is the pin value sampled k+1 edges ago; an edge is
  // acted on S edges after the pin is first sampled.
  task automatic m_step();
    bit hb, vb, cs, bl, t, a, burst_c;
    int len_c, lines_c, cs_c;
    hb = h_hb[S-1] && !h_hb[S];
    vb = h_vb[S-1] && !h_vb[S];
    cs = !h_cs[S-1] && h_cs[S];
    bl = !h_bn[S-1];
    t  = bus.xin_tick_i;
    a  = bus.snap_ack_i;
    for (int k = S; k > 0; k--) begin
      h_hb[k] = h_hb[k-1]; h_vb[k] = h_vb[k-1];
      h_cs[k] = h_cs[k-1]; h_bn[k] = h_bn[k-1];
    end
    h_hb[0] = bus.hblank; h_vb[0] = bus.vblank;
    h_cs[0] = bus.csync_n; h_bn[0] = bus.burst_n;
    if (bus.clear_i) begin
      m_clear_state();
      return;
    end
    len_c   = hb ? sat(m_dot + int'(t)) : m_len;
    m_dot   = hb ? 0 : sat(m_dot + int'(t));
    m_len   = len_c;
    lines_c = sat(m_lines + int'(hb));
    cs_c    = sat(m_cs + int'(cs));
    burst_c = m_burst | bl;
    if (vb) begin
      m_frame = (m_frame + 1) % (MAXV + 1);
      if (!m_valid || a) begin
        s_len = len_c; s_lines = lines_c; s_cs = cs_c; s_frame = m_frame;
        m_valid = 1; m_part = m_pend; m_nob = !burst_c; m_pend = 0;
      end else begin
        m_ovr = 1;
      end
      m_lines = 0; m_cs = 0; m_burst = 0;
    end else begin
      m_lines = lines_c; m_cs = cs_c; m_burst = burst_c;
      if (a) m_valid = 0;
    end
  endtask

  // Model advances on the same edges as the DUT.
  always @(posedge clock or negedge reset) begin
    if (!reset) m_reset();
    else        m_step();
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare every output against the model away from the active edge.
  always @(negedge clock) begin
    chk("valid",    int'(bus.snap_valid_o),    int'(m_valid));
    chk("line_len", int'(bus.snap_line_len_o), s_len);
    chk("lines",    int'(bus.snap_lines_o),    s_lines);
    chk("csync",    int'(bus.snap_csync_o),    s_cs);
    chk("frame",    int'(bus.snap_frame_o),    s_frame);
    chk("partial",  int'(bus.snap_partial_o),  int'(m_part));
    chk("noburst",  int'(bus.snap_noburst_o),  int'(m_nob));
    chk("overrun",  int'(bus.overrun_o),       int'(m_ovr));
  end

  // ---------------- stimulus ----------------
  task automatic all_zero(input string tag);
    chk({tag, "_valid"},   int'(bus.snap_valid_o),    0);
    chk({tag, "_len"},     int'(bus.snap_line_len_o), 0);
    chk({tag, "_lines"},   int'(bus.snap_lines_o),    0);
    chk({tag, "_csync"},   int'(bus.snap_csync_o),    0);
    chk({tag, "_frame"},   int'(bus.snap_frame_o),    0);
    chk({tag, "_partial"}, int'(bus.snap_partial_o),  0);
    chk({tag, "_noburst"}, int'(bus.snap_noburst_o),  0);
    chk({tag, "_overrun"}, int'(bus.overrun_o),       0);
  endtask

  // One line of per cycles: hblank rises at cycle 0, csync pulse at 2..4,
  // burst at 1..3, optional vblank pulse from vb_off with an ack landing on
  // the synchronised vblank edge.
  task automatic do_line(input int per, input bit cs_pulse, input bit burst,
                         input int vb_off, input bit ack_vb, input int tm);
    for (int c = 0; c < per; c++) begin
      bus.hblank  = (c < 8);
      bus.csync_n = !(cs_pulse && c >= 2 && c < 5);
      bus.burst_n = !(burst && c >= 1 && c < 4);
      if (vb_off >= 0 && c == vb_off)      bus.vblank = 1'b1;
      if (vb_off >= 0 && c == vb_off + 15) bus.vblank = 1'b0;
      bus.snap_ack_i = ack_vb && (vb_off >= 0) && (c == vb_off + S);
      bus.xin_tick_i = (tm == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    bus.snap_ack_i = 1'b0;
  endtask

  task automatic frame(input int nl, input int per, input int alt_per,
                       input int ncs, input bit burst, input bit same,
                       input bit ack_vb, input int tm);
    for (int i = 0; i < nl; i++) begin
      do_line((i == nl - 2) ? alt_per : per, i < ncs, burst,
              (i == nl - 1) ? (same ? 0 : 5) : -1,
              (i == nl - 1) && ack_vb, tm);
    end
  endtask

  task automatic ack_now();
    bus.snap_ack_i = 1'b1;
    @(negedge clock);
    bus.snap_ack_i = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    bus.xin_tick_i = 1'b0; bus.clear_i = 1'b0; bus.snap_ack_i = 1'b0;
    bus.hblank = 1'b0; bus.vblank = 1'b0; bus.csync_n = 1'b1; bus.burst_n = 1'b1;
    repeat (3) @(negedge clock);
    all_zero("reset");
    reset = 1'b1;
    @(negedge clock);

    // Three acked frames of 12 lines x 34 ticks.
    frame(12, 34, 34, 12, 1, 0, 0, 0);
    chk("f1_frame", int'(bus.snap_frame_o), 1);
    chk("f1_partial", int'(bus.snap_partial_o), 1);
    chk("f1_lines", int'(bus.snap_lines_o), 12);
    ack_now();
    chk("f1_acked_valid", int'(bus.snap_valid_o), 0);
    chk("f1_held_frame", int'(bus.snap_frame_o), 1);
    frame(12, 34, 34, 12, 1, 0, 0, 0);
    chk("f2_len", int'(bus.snap_line_len_o), 34);
    chk("f2_lines", int'(bus.snap_lines_o), 12);
    chk("f2_csync", int'(bus.snap_csync_o), 12);
    chk("f2_frame", int'(bus.snap_frame_o), 2);
    chk("f2_partial", int'(bus.snap_partial_o), 0);
    chk("f2_noburst", int'(bus.snap_noburst_o), 0);
    ack_now();
    frame(12, 34, 34, 12, 1, 0, 0, 0);
    chk("f3_frame", int'(bus.snap_frame_o), 3);
    ack_now();

    // Overrun: frame 4 unread, frame 5 dropped, frame 6 acked on vb edge.
    frame(12, 34, 34, 12, 1, 0, 0, 0);
    frame(10, 36, 36, 10, 1, 0, 0, 0);
    chk("ovr_valid", int'(bus.snap_valid_o), 1);
    chk("ovr_held_frame", int'(bus.snap_frame_o), 4);
    chk("ovr_held_lines", int'(bus.snap_lines_o), 12);
    chk("ovr_held_len", int'(bus.snap_line_len_o), 34);
    chk("ovr_flag", int'(bus.overrun_o), 1);
    frame(10, 36, 36, 10, 1, 0, 1, 0);
    chk("ackvb_valid", int'(bus.snap_valid_o), 1);
    chk("ackvb_frame", int'(bus.snap_frame_o), 6);
    chk("ackvb_lines", int'(bus.snap_lines_o), 10);
    chk("ackvb_len", int'(bus.snap_line_len_o), 36);
    ack_now();

    // hblank and vblank rise together; previous line is 40 ticks.
    frame(8, 34, 40, 8, 1, 1, 0, 0);
    chk("same_lines", int'(bus.snap_lines_o), 8);
    chk("same_len", int'(bus.snap_line_len_o), 40);
    ack_now();

    // Irregular ticks, checked by the model only.
    frame(9, 38, 35, 4, 1, 0, 0, 1);
    ack_now();

    // No burst in a 16-line frame with 15 csync pulses.
    frame(16, 34, 34, 15, 0, 0, 0, 0);
    chk("nb_noburst", int'(bus.snap_noburst_o), 1);
    chk("nb_csync", int'(bus.snap_csync_o), 15);
    chk("nb_lines", int'(bus.snap_lines_o), 16);
    chk("nb_frame", int'(bus.snap_frame_o), 9);
    ack_now();

    // Saturating line length.
    bus.xin_tick_i = 1'b1;
    repeat (70000) @(negedge clock);
    do_line(34, 0, 1, 5, 0, 0);
    repeat (4) @(negedge clock);
    chk("sat_len", int'(bus.snap_line_len_o), 16'hFFFF);
    chk("sat_lines", int'(bus.snap_lines_o), 1);
    chk("sat_frame", int'(bus.snap_frame_o), 10);
    ack_now();

    // Re-create an overrun, then reset asynchronously mid-line.
    frame(12, 34, 34, 12, 1, 0, 0, 0);
    frame(12, 34, 34, 12, 1, 0, 0, 0);
    chk("pre_rst_overrun", int'(bus.overrun_o), 1);
    do_line(34, 1, 1, -1, 0, 0);
    bus.hblank = 1'b1;
    repeat (8) @(negedge clock);
    bus.hblank = 1'b0;
    repeat (10) @(negedge clock);
    #2 reset = 1'b0;
    #1 all_zero("async_rst");
    @(negedge clock);
    reset = 1'b1;
    frame(12, 34, 34, 12, 1, 0, 0, 0);
    chk("rst_partial", int'(bus.snap_partial_o), 1);
    chk("rst_overrun", int'(bus.overrun_o), 0);
    chk("rst_frame", int'(bus.snap_frame_o), 1);
    ack_now();

    // Overrun again, then synchronous clear mid-frame.
    frame(12, 34, 34, 12, 1, 0, 0, 0);
    frame(12, 34, 34, 12, 1, 0, 0, 0);
    chk("pre_clr_overrun", int'(bus.overrun_o), 1);
    chk("pre_clr_frame", int'(bus.snap_frame_o), 2);
    do_line(34, 1, 1, -1, 0, 0);
    do_line(34, 1, 1, -1, 0, 0);
    bus.clear_i = 1'b1;
    @(negedge clock);
    bus.clear_i = 1'b0;
    all_zero("clear");
    frame(12, 34, 34, 12, 1, 0, 0, 0);
    chk("clr_partial", int'(bus.snap_partial_o), 1);
    chk("clr_overrun", int'(bus.overrun_o), 0);
    chk("clr_frame", int'(bus.snap_frame_o), 1);
    ack_now();
    repeat (4) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppu_timing_monitor.md
Name: ppu_timing_monitor

Overview:
- Consumes the PPU video timing outputs (hblank, vblank, csync_n, burst_n) that ppu_control already carries, plus the per-edge xin tick from the PPU clock generator.
- Measures line length in xin ticks, lines per frame, csync pulses per frame, and a running frame count.
- Presents one snapshot per frame to the host register interface using a valid/ack handshake.
- Sits downstream of ppu_control, alongside ppu_interrupt; the host reads it to check PPU timing while stepping xin.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each asynchronous PPU input (minimum 2).
- CNT_W, 16, width of every counter and snapshot field.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- xin_tick_i  input  1  one-cycle pulse per xin rising edge, synchronous to clock
- clear_i  input  1  synchronous clear of counters, snapshot and flags
- snap_ack_i  input  1  host consumed the snapshot
- hblank  input  1  PPU hblank, asynchronous
- vblank  input  1  PPU vblank, asynchronous
- csync_n  input  1  PPU composite sync, asynchronous
- burst_n  input  1  PPU colour burst, asynchronous
- snap_valid_o  output  1  snapshot registers hold an unread frame
- snap_line_len_o  output  CNT_W  xin ticks in the last complete line of the frame
- snap_lines_o  output  CNT_W  hblank rising edges in the frame
- snap_csync_o  output  CNT_W  csync_n falling edges in the frame
- snap_frame_o  output  CNT_W  frame number of this snapshot
- snap_partial_o  output  1  this snapshot covers a frame that started after reset or clear
- snap_noburst_o  output  1  no burst_n low was seen during the frame
- overrun_o  output  1  sticky: a frame ended while snap_valid_o=1 and was not acked

Behaviour:
- Reset: every output is 0, all counters are 0, and partial_pending=1.
- Synchroniser reset values: hblank/vblank 0, csync_n/burst_n 1.
- Input synchronisation: each input passes through SYNC_STAGES flops plus one delay flop for edge detect. Edge pulses (hb_rise, vb_rise, cs_fall) are one cycle long, SYNC_STAGES+1 cycles after the pin changes.
- dot_cnt: +1 per xin_tick_i, saturating at all-ones.
  - On hb_rise: line_len <= dot_cnt + xin_tick_i (saturated), and dot_cnt <= 0.
- line_cnt: +1 on hb_rise. csync_cnt: +1 on cs_fall. Both saturate.
- burst_seen: set whenever synchronised burst_n=0.
- On vb_rise, the frame ends:
  - Closing values: lines = line_cnt + hb_rise, csync = csync_cnt + cs_fall, len = line_len, updated first if hb_rise is in the same cycle. Same-cycle events belong to the ending frame.
  - frame_cnt increments (wraps) and the snapshot frame = new frame_cnt.
  - Snapshot load condition: snap_valid_o=0, or snap_ack_i=1 in the same cycle. If met, load all snap_* fields, set snap_valid_o=1, snap_partial_o=partial_pending, snap_noburst_o=~burst_seen, and clear partial_pending.
  - Otherwise the existing snapshot is held unchanged, overrun_o<=1, and partial_pending is left unchanged.
  - In both cases line_cnt, csync_cnt and burst_seen restart at 0.
- snap_ack_i with no concurrent load clears snap_valid_o next cycle. An ack while snap_valid_o=0 has no effect. Snapshot fields hold their values after ack.
- overrun_o is cleared only by clear_i or reset.
- clear_i: the same state as reset, except the synchronisers keep running. clear_i wins over every same-cycle event.
- Asynchronous reset mid-frame: state returns to reset values immediately, and the first following snapshot has snap_partial_o=1.
- No event depends on hblank/vblank falling edges. csync rising edges and burst edges are not counted.

Test Plan:
- Reset, then 3 frames of 262 lines x 341 ticks (hblank rising every 341 ticks, vblank rising every 262 lines), acking each snapshot -> frame 1 has partial=1. Frames 2 and 3: line_len=341, lines=262, snap_frame=2 and 3, partial=0.
- Same stimulus with no ack after frame 1 -> snap_valid stays 1, frame-1 fields are held, and overrun_o=1 at the frame-2 vblank. Ack in the same cycle as the frame-3 vb_rise -> frame-3 data loads with snap_frame=3 and valid stays 1.
- hblank and vblank rising in the same synchronised cycle, with a tick present -> lines includes that line, and line_len = dot_cnt+1.
- xin_tick_i held high for 70000 cycles with no hblank -> line_len saturates at 16'hFFFF without wrapping.
- burst_n held high for a full frame -> snap_noburst_o=1. 15 csync_n low pulses in the frame -> snap_csync=15.
- Reset asserted mid-line, and clear_i pulsed mid-frame -> all outputs 0 immediately for reset, one cycle later for clear. The next snapshot has partial=1 and overrun=0.
